// File: rtl/pdp_pkg.sv
// Shared definitions for the pseudo-dual-port EBR wrapper blocks (read and write side).
package pdp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pdp_state_t;

    localparam int PDP_FIFO_DEPTH = 4;

    // Read latency implied by each EBR REGMODE setting.
    localparam int PDP_LAT_NOREG  = 1;
    localparam int PDP_LAT_OUTREG = 2;

    function automatic int regmode_latency(input string regmode);
        return (regmode == "OUTREG") ? PDP_LAT_OUTREG : PDP_LAT_NOREG;
    endfunction

endpackage

// File: rtl/pdp_rd_fifo.sv
// Small output FIFO for the read streamer; depth fixed by the package, no overflow
// protection because the caller only pushes against reserved credit.
module pdp_rd_fifo
    import pdp_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    push,
    input  logic [WIDTH-1:0]                        din,
    input  logic                                    pop,
    output logic [WIDTH-1:0]                        dout,
    output logic                                    empty,
    output logic [$clog2(PDP_FIFO_DEPTH+1)-1:0]     count
);
    localparam int PW = $clog2(PDP_FIFO_DEPTH);
    localparam int CW = $clog2(PDP_FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem [PDP_FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/pdp_rd_stream.sv
// Sequential read engine for a pseudo-dual-port EBR: turns (addr, len) commands into
// RAM reads and returns the words as a valid/ready stream with a last marker.
module pdp_rd_stream
    import pdp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 9,
    parameter int RD_LATENCY = 1,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  CLKR,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    output logic [ADDR_WIDTH-1:0] ADR,
    output logic                  CER,
    output logic                  OCER,
    input  logic [DATA_WIDTH-1:0] DO,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int CW = $clog2(PDP_FIFO_DEPTH + 1);

    if (RD_LATENCY != PDP_LAT_NOREG && RD_LATENCY != PDP_LAT_OUTREG) begin : g_bad_latency
        $error("pdp_rd_stream: RD_LATENCY must be 1 (NOREG) or 2 (OUTREG)");
    end

    pdp_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [RD_LATENCY:1]   vld_pipe, last_pipe;
    logic [CW-1:0]         fifo_count, inflight;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  fifo_empty, issue, pop;

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    // Every read reserves a FIFO slot at issue, so the latency pipe never has to stall.
    assign issue = (state == RUN) && (remaining != '0) &&
                   ((fifo_count + inflight) < CW'(PDP_FIFO_DEPTH));
    assign pop   = M_VALID && M_READY;

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign CER       = issue;
    assign ADR       = addr_cnt;
    assign OCER      = (RD_LATENCY == PDP_LAT_OUTREG) ? vld_pipe[1] : 1'b0;
    assign M_VALID   = !fifo_empty;
    assign M_DATA    = fifo_dout[DATA_WIDTH-1:0];
    assign M_LAST    = fifo_dout[DATA_WIDTH] && M_VALID;

    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[1]  <= issue;
            last_pipe[1] <= issue && (remaining == LEN_WIDTH'(1));
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: if (CMD_VALID) begin
                    addr_cnt  <= CMD_ADDR;
                    remaining <= CMD_LEN;
                    if (CMD_LEN != '0) state <= RUN;
                    else               DONE  <= 1'b1;
                end
                RUN: if (issue) begin
                    addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
                    remaining <= remaining - LEN_WIDTH'(1);
                    if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
                end
                DRAIN: if (pop && M_LAST) begin
                    state <= IDLE;
                    DONE  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pdp_rd_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
        .clk   (CLKR),
        .rst   (RST),
        .push  (vld_pipe[RD_LATENCY]),
        .din   ({last_pipe[RD_LATENCY], DO}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_pdp_rd_stream.sv
// Drives NOREG and OUTREG instances in lockstep and checks both against a
// queue-based model of the expected addresses, beats and DONE timing.
`timescale 1ns/1ps
module tb_pdp_rd_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, m_ready;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [8:0]  mem [1024];
    int          vectors = 0, miscompares = 0;
    int          rdy_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
    logic [9:0]  want [$];

    task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (lat %0d): got 0x%0h, expected 0x%0h at %0t", name, lat, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int lat, input logic [9:0] got [$], input logic [9:0] exp [$]);
        chk({name, "_len"}, lat, got.size(), exp.size());
        foreach (exp[i]) if (i < got.size()) chk(name, lat, got[i], exp[i]);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = k + 1;
        logic       cmd_ready, cer, ocer, m_valid, m_last, busy, done;
        logic [9:0] adr;
        logic [8:0] rd_do, m_data, lat_q;

        pdp_rd_stream #(.RD_LATENCY(LAT)) u_dut (
            .CLKR(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
            .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .ADR(adr), .CER(cer), .OCER(ocer),
            .DO(rd_do), .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
            .M_LAST(m_last), .BUSY(busy), .DONE(done)
        );

        // EBR read port: NOREG captures on CER, OUTREG adds an OCER-enabled register.
        always @(posedge clk) begin
            if (cer) lat_q <= mem[adr];
            if (LAT == 1) begin
                if (cer) rd_do <= mem[adr];
            end else if (ocer) begin
                rd_do <= lat_q;
            end
        end

        logic [9:0] expq [$], adrq [$], beat_log [$], adr_log [$];
        int cyc = 0, acc_cyc = 0, first_cyc = 0, cur_len = 0;
        int issued = 0, popped = 0, cer_cnt = 0, beat_cnt = 0;
        bit done_due = 0, exp_busy = 0, hold = 0, first_pending = 0, all_ready = 0, prev_cer = 0;
        logic [9:0] hold_word;

        always @(negedge clk) begin
            bit dn, bn;
            logic [9:0] w, a;
            cyc++;
            dn = 0;
            bn = exp_busy;
            if (rst) begin
                chk("rst_outs", LAT, {cmd_ready, cer, ocer, m_valid, m_last, busy, done}, 7'b1000000);
                chk("rst_adr", LAT, adr, 0);
                expq.delete(); adrq.delete();
                issued = 0; popped = 0; hold = 0; first_pending = 0; prev_cer = 0; bn = 0;
            end else begin
                chk("done", LAT, done, done_due);
                chk("busy", LAT, busy, exp_busy);
                chk("cmd_ready", LAT, cmd_ready, !exp_busy);
                chk("ocer", LAT, ocer, (LAT == 2) ? prev_cer : 1'b0);
                if (hold) chk("hold_stable", LAT, {m_valid, m_last, m_data}, {1'b1, hold_word});
                if (cer) begin
                    cer_cnt++;
                    issued++;
                    adr_log.push_back(adr);
                    if (adrq.size() == 0) chk("cer_unexpected", LAT, cer, 0);
                    else chk("adr", LAT, adr, adrq.pop_front());
                    chk("credit", LAT, (issued - popped) <= 4, 1);
                end
                if (first_pending && m_valid) begin
                    chk("first_latency", LAT, cyc - acc_cyc, LAT + 2);
                    first_pending = 0;
                end
                if (m_valid && expq.size() == 0) begin
                    chk("beat_unexpected", LAT, m_valid, 0);
                end else if (m_valid && m_ready) begin
                    w = expq.pop_front();
                    chk("beat", LAT, {m_last, m_data}, w);
                    beat_log.push_back({1'b0, m_data});
                    popped++;
                    if (beat_cnt == 0) begin first_cyc = cyc; all_ready = 1; end
                    beat_cnt++;
                    if (w[9]) begin
                        dn = 1;
                        bn = 0;
                        if (all_ready) chk("throughput", LAT, cyc - first_cyc, cur_len - 1);
                    end
                end
                if (beat_cnt > 0 && !m_ready) all_ready = 0;
                hold      = m_valid && !m_ready;
                hold_word = {m_last, m_data};
                prev_cer  = cer;
                if (cmd_valid && cmd_ready) begin
                    cer_cnt = 0; beat_cnt = 0; issued = 0; popped = 0;
                    beat_log.delete(); adr_log.delete();
                    cur_len = cmd_len;
                    if (cmd_len == 0) dn = 1;
                    else begin
                        bn = 1;
                        first_pending = 1;
                        acc_cyc = cyc;
                        for (int i = 0; i < cmd_len; i++) begin
                            a = 10'(cmd_addr + i);
                            adrq.push_back(a);
                            expq.push_back({i == cmd_len - 1, mem[a]});
                        end
                    end
                end
            end
            done_due = dn;
            exp_busy = bn;
        end
    end

    task automatic send(input logic [9:0] a, input logic [10:0] n);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = n;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((g_dut[0].busy || g_dut[1].busy) && n < 6000);
        chk({"timeout_", tag}, 0, n >= 6000, 0);
    endtask

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                2:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 9'(i + 'h10);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic stream, ready held high
        rdy_mode = 1;
        send(10'h010, 11'd4);
        wait_idle("basic");
        want = {10'h020, 10'h021, 10'h022, 10'h023};
        chk_log("basic_beats", 1, g_dut[0].beat_log, want);
        chk_log("basic_beats", 2, g_dut[1].beat_log, want);

        // Toggling and random backpressure
        rdy_mode = 2;
        send(10'($urandom_range(0, 1023)), 11'd16);
        wait_idle("toggle");
        chk("toggle_count", 1, g_dut[0].beat_cnt, 16);
        chk("toggle_count", 2, g_dut[1].beat_cnt, 16);
        rdy_mode = 3;
        send(10'($urandom_range(0, 1023)), 11'd16);
        wait_idle("random16");

        // Address wrap
        rdy_mode = 1;
        send(10'h3FE, 11'd4);
        wait_idle("wrap");
        want = {10'h3FE, 10'h3FF, 10'h000, 10'h001};
        chk_log("wrap_adr", 1, g_dut[0].adr_log, want);
        chk_log("wrap_adr", 2, g_dut[1].adr_log, want);

        // Zero length: DONE only
        send(10'h123, 11'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("len0_cer", 1, g_dut[0].cer_cnt, 0);
        chk("len0_cer", 2, g_dut[1].cer_cnt, 0);

        // Full-depth command
        rdy_mode = 3;
        send(10'h155, 11'd1024);
        wait_idle("len1024");
        chk("len1024_count", 1, g_dut[0].beat_cnt, 1024);
        chk("len1024_count", 2, g_dut[1].beat_cnt, 1024);

        // Stall: consumer not ready for 20 cycles
        rdy_mode = 0;
        send(10'h200, 11'd8);
        repeat (20) begin @(posedge clk); #1; end
        chk("stall_cer", 1, g_dut[0].cer_cnt, 4);
        chk("stall_cer", 2, g_dut[1].cer_cnt, 4);
        chk("stall_valid", 1, g_dut[0].m_valid, 1);
        chk("stall_valid", 2, g_dut[1].m_valid, 1);
        rdy_mode = 1;
        wait_idle("stall");
        chk("stall_count", 1, g_dut[0].beat_cnt, 8);
        chk("stall_count", 2, g_dut[1].beat_cnt, 8);

        // Reset in the middle of a command, then a fresh command
        send(10'h040, 11'd8);
        n = 0;
        while (g_dut[0].beat_cnt < 3 && n < 100) begin @(posedge clk); #1; n++; end
        chk("rst_wait_timeout", 0, n >= 100, 0);
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        send(10'h100, 11'd2);
        wait_idle("post_reset");
        want = {10'h110, 10'h111};
        chk_log("post_reset_beats", 1, g_dut[0].beat_log, want);
        chk_log("post_reset_beats", 2, g_dut[1].beat_log, want);

        // Random commands over random RAM contents
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
            rdy_mode = $urandom_range(1, 3);
            send(10'($urandom_range(0, 1023)),
                 ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 300)) : 11'($urandom_range(0, 24)));
            wait_idle("random");
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
